// File: rtl/fpu_ctrl_pkg.sv
// Shared types and default configuration for the FPU issue controller.
package fpu_ctrl_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned DEF_N_UNITS = 3;
  localparam int unsigned DEF_OPC_W   = 2;
  localparam int unsigned DEF_TAG_W   = 5;
  localparam int unsigned DEF_LAT_W   = 4;
  localparam int unsigned DEF_TIMEOUT = 15;

  // Packed {LAT[2], LAT[1], LAT[0]}: fabs=1, fneg=1, fadd-class=4
  localparam logic [DEF_N_UNITS*DEF_LAT_W-1:0] DEF_LATENCIES = 12'h411;

  localparam logic [DEF_OPC_W-1:0] OPC_FABS = 2'd0;
  localparam logic [DEF_OPC_W-1:0] OPC_FNEG = 2'd1;
  localparam logic [DEF_OPC_W-1:0] OPC_FADD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Request, unit-bank and response signals of the FPU issue controller.
interface fpu_issue_ctrl_if #(
  parameter int unsigned N_UNITS = fpu_ctrl_pkg::DEF_N_UNITS,
  parameter int unsigned OPC_W   = fpu_ctrl_pkg::DEF_OPC_W,
  parameter int unsigned TAG_W   = fpu_ctrl_pkg::DEF_TAG_W
) ();

  localparam int unsigned DW = fpu_ctrl_pkg::DATA_W;

  logic                  req_valid;
  logic                  req_ready;
  logic [OPC_W-1:0]      req_opc;
  logic [DW-1:0]         req_a;
  logic [DW-1:0]         req_b;
  logic [TAG_W-1:0]      req_tag;

  logic [DW-1:0]         unit_a;
  logic [DW-1:0]         unit_b;
  logic [N_UNITS-1:0]    unit_sel;
  logic [DW*N_UNITS-1:0] unit_result;
  logic [N_UNITS-1:0]    unit_ready;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [DW-1:0]         resp_result;
  logic [TAG_W-1:0]      resp_tag;
  logic                  resp_err;
  logic                  busy;

  // Controller side
  modport master (
    input  req_valid, req_opc, req_a, req_b, req_tag,
    input  unit_result, unit_ready, resp_ready,
    output req_ready, unit_a, unit_b, unit_sel,
    output resp_valid, resp_result, resp_tag, resp_err, busy
  );

  // Core and unit-bank side
  modport slave (
    output req_valid, req_opc, req_a, req_b, req_tag,
    output unit_result, unit_ready, resp_ready,
    input  req_ready, unit_a, unit_b, unit_sel,
    input  resp_valid, resp_result, resp_tag, resp_err, busy
  );

endinterface

// File: rtl/fpu_issue_ctrl.sv
// Single-issue sequencer: accepts one FP request, drives the selected fixed-latency
// unit, waits out its latency/ready, and holds the result until the core takes it.
module fpu_issue_ctrl
  import fpu_ctrl_pkg::*;
#(
  parameter int unsigned                  N_UNITS   = DEF_N_UNITS,
  parameter int unsigned                  OPC_W     = DEF_OPC_W,
  parameter int unsigned                  TAG_W     = DEF_TAG_W,
  parameter int unsigned                  LAT_W     = DEF_LAT_W,
  parameter logic [N_UNITS*LAT_W-1:0]     LATENCIES = DEF_LATENCIES,
  parameter int unsigned                  TIMEOUT   = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  fpu_issue_ctrl_if.master bus
);

  fsm_state_e          state_q;
  logic [OPC_W-1:0]    opc_q;
  logic [LAT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   unit_a_q;
  logic [DATA_W-1:0]   unit_b_q;
  logic [N_UNITS-1:0]  unit_sel_q;
  logic                req_ready_q;
  logic                busy_q;
  logic                resp_valid_q;
  logic [DATA_W-1:0]   resp_result_q;
  logic [TAG_W-1:0]    resp_tag_q;
  logic                resp_err_q;

  logic [LAT_W-1:0]    lat_sel_c;
  logic [DATA_W-1:0]   res_sel_c;
  logic                rdy_sel_c;
  logic                opc_ok_c;

  // Latency, result slice and ready flag of the unit addressed by the latched opcode
  always_comb begin
    lat_sel_c = '0;
    res_sel_c = '0;
    rdy_sel_c = 1'b0;
    for (int unsigned i = 0; i < N_UNITS; i++) begin
      if (opc_q == OPC_W'(i)) begin
        lat_sel_c = LATENCIES[i*LAT_W +: LAT_W];
        res_sel_c = bus.unit_result[i*DATA_W +: DATA_W];
        rdy_sel_c = bus.unit_ready[i];
      end
    end
  end

  assign opc_ok_c = (32'(bus.req_opc) < N_UNITS);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      opc_q         <= '0;
      cnt_q         <= '0;
      unit_a_q      <= '0;
      unit_b_q      <= '0;
      unit_sel_q    <= '0;
      req_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      resp_tag_q    <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            opc_q       <= bus.req_opc;
            resp_tag_q  <= bus.req_tag;
            unit_a_q    <= bus.req_a;
            unit_b_q    <= bus.req_b;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (opc_ok_c) begin
              state_q    <= WAIT;
              unit_sel_q <= N_UNITS'(1) << bus.req_opc;
            end else begin
              // Unknown unit: complete with an error without touching the bank
              state_q       <= RESP;
              resp_valid_q  <= 1'b1;
              resp_result_q <= '0;
              resp_err_q    <= 1'b1;
            end
          end
        end

        WAIT: begin
          // Completion is checked before the watchdog so it wins a tie
          if ((cnt_q >= lat_sel_c) && rdy_sel_c) begin
            state_q       <= RESP;
            unit_sel_q    <= '0;
            resp_valid_q  <= 1'b1;
            resp_result_q <= res_sel_c;
            resp_err_q    <= 1'b0;
          end else if (cnt_q == LAT_W'(TIMEOUT)) begin
            state_q       <= RESP;
            unit_sel_q    <= '0;
            resp_valid_q  <= 1'b1;
            resp_result_q <= '0;
            resp_err_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + LAT_W'(1);
          end
        end

        RESP: begin
          if (bus.resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
          end
        end

        default: begin
          state_q      <= IDLE;
          unit_sel_q   <= '0;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.unit_a      = unit_a_q;
  assign bus.unit_b      = unit_b_q;
  assign bus.unit_sel    = unit_sel_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_result = resp_result_q;
  assign bus.resp_tag    = resp_tag_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: transaction-level reference model plus unit-bank models,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fpu_issue_ctrl;
  import fpu_ctrl_pkg::*;

  localparam int TO = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fpu_issue_ctrl_if bus ();

  fpu_issue_ctrl dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  // Unit latencies written out from 12'h411
  int lat_tab [3] = '{1, 1, 4};
  int age     [3] = '{0, 0, 0};

  // Reference model: transaction view of the controller
  bit          m_idle, m_inflight, m_resp, m_err;
  int          m_t, m_done;
  logic [1:0]  m_opc;
  logic [31:0] m_a, m_b, m_res;
  logic [4:0]  m_tag;
  bit          rdy_pat [0:31];
  int          force_pct = -1;
  bit          chk_en = 1'b0;

  function automatic logic [31:0] unit_fn(int u, logic [31:0] a, logic [31:0] b);
    case (u)
      0:       return a & 32'h7FFF_FFFF;
      1:       return a ^ 32'h8000_0000;
      default: return a + b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Decide the whole wait phase at acceptance from the pregenerated ready pattern
  task automatic plan_txn();
    int pct;
    if (force_pct >= 0) pct = force_pct;
    else begin
      int r = $urandom_range(0, 9);
      pct = (r < 4) ? 100 : (r < 7) ? 60 : (r < 9) ? 15 : 0;
    end
    for (int j = 0; j < 32; j++) rdy_pat[j] = ($urandom_range(0, 99) < pct);
    m_done = TO + 1;
    m_err  = 1'b1;
    m_res  = 32'h0;
    for (int j = lat_tab[m_opc] + 1; j <= TO + 1; j++) begin
      if (rdy_pat[j]) begin
        m_done = j;
        m_err  = 1'b0;
        m_res  = unit_fn(int'(m_opc), m_a, m_b);
        break;
      end
    end
  endtask

  task automatic model_edge();
    if (!reset) begin
      m_idle = 1'b1; m_inflight = 1'b0; m_resp = 1'b0;
      m_a = 32'h0; m_b = 32'h0;
    end else if (m_idle) begin
      if (bus.req_valid) begin
        m_idle = 1'b0;
        m_opc = bus.req_opc; m_a = bus.req_a; m_b = bus.req_b; m_tag = bus.req_tag;
        if (int'(bus.req_opc) >= 3) begin
          m_resp = 1'b1; m_err = 1'b1; m_res = 32'h0;
        end else begin
          m_inflight = 1'b1; m_t = 0;
          plan_txn();
        end
      end
    end else if (m_inflight) begin
      m_t++;
      if (m_t == m_done) begin
        m_inflight = 1'b0;
        m_resp = 1'b1;
      end
    end else if (m_resp && bus.resp_ready) begin
      m_resp = 1'b0;
      m_idle = 1'b1;
    end
  endtask

  // Unit bank: each unit shows its result only once LAT edges have passed since selection
  task automatic drive_units();
    for (int i = 0; i < 3; i++) begin
      if (bus.unit_sel[i] === 1'b1) age[i]++;
      else age[i] = 0;
      if (age[i] >= lat_tab[i] + 1) bus.unit_result[i*32 +: 32] = unit_fn(i, bus.unit_a, bus.unit_b);
      else bus.unit_result[i*32 +: 32] = $urandom;
      bus.unit_ready[i] = 1'($urandom_range(0, 1));
    end
    if (m_inflight && (m_t + 1 < 32)) bus.unit_ready[m_opc] = rdy_pat[m_t + 1];
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    drive_units();
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(bus.req_ready), 32'(m_idle));
      chk("busy", 32'(bus.busy), 32'(!m_idle));
      chk("resp_valid", 32'(bus.resp_valid), 32'(m_resp));
      chk("unit_sel", 32'(bus.unit_sel), m_inflight ? (32'd1 << m_opc) : 32'd0);
      chk("unit_a", bus.unit_a, m_a);
      chk("unit_b", bus.unit_b, m_b);
      if (m_resp) begin
        chk("resp_result", bus.resp_result, m_res);
        chk("resp_tag", 32'(bus.resp_tag), 32'(m_tag));
        chk("resp_err", 32'(bus.resp_err), 32'(m_err));
      end
    end
  end

  task automatic request(input logic [1:0] opc, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
    bus.req_valid = 1'b1; bus.req_opc = opc; bus.req_a = a; bus.req_b = b; bus.req_tag = tag;
  endtask

  initial begin
    reset = 1'b0;
    bus.req_valid = 1'b0; bus.req_opc = '0; bus.req_a = '0; bus.req_b = '0; bus.req_tag = '0;
    bus.resp_ready = 1'b0; bus.unit_result = '0; bus.unit_ready = '0;
    m_idle = 1'b1; m_inflight = 1'b0; m_resp = 1'b0; m_a = '0; m_b = '0;
    cycle();
    chk_en = 1'b1;
    cycle();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_unit_sel", 32'(bus.unit_sel), 32'd0);
    reset = 1'b1;
    cycle();

    // fabs, 1-cycle unit: response two edges after accept
    force_pct = 100;
    bus.resp_ready = 1'b1;
    request(OPC_FABS, 32'hBF80_0000, 32'h0, 5'd9);
    cycle();
    bus.req_valid = 1'b0;
    chk("d1_sel", 32'(bus.unit_sel), 32'b001);
    cycle();
    chk("d1_early", 32'(bus.resp_valid), 32'd0);
    cycle();
    chk("d1_valid", 32'(bus.resp_valid), 32'd1);
    chk("d1_result", bus.resp_result, 32'h3F80_0000);
    chk("d1_tag", 32'(bus.resp_tag), 32'd9);
    chk("d1_err", 32'(bus.resp_err), 32'd0);
    cycle();
    chk("d1_idle", 32'(bus.req_ready), 32'd1);

    // fadd-class, 4-cycle unit, then back-pressure on the response
    bus.resp_ready = 1'b0;
    request(OPC_FADD, 32'h0000_1234, 32'h0000_0100, 5'd17);
    cycle();
    bus.req_valid = 1'b0;
    for (int n = 0; n < 5; n++) begin
      chk("d2_sel", 32'(bus.unit_sel), 32'b100);
      chk("d2_wait", 32'(bus.resp_valid), 32'd0);
      cycle();
    end
    chk("d2_sel_off", 32'(bus.unit_sel), 32'd0);
    chk("d2_valid", 32'(bus.resp_valid), 32'd1);
    chk("d2_result", bus.resp_result, 32'h0000_1334);
    request(OPC_FABS, 32'h1, 32'h2, 5'd1);
    for (int n = 0; n < 6; n++) begin
      cycle();
      chk("bp_valid", 32'(bus.resp_valid), 32'd1);
      chk("bp_result", bus.resp_result, 32'h0000_1334);
      chk("bp_tag", 32'(bus.resp_tag), 32'd17);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    cycle();
    chk("bp_release", 32'(bus.req_ready), 32'd1);
    chk("bp_release_v", 32'(bus.resp_valid), 32'd0);
    bus.resp_ready = 1'b0;

    // Hung fneg unit: watchdog error after TIMEOUT+1 wait edges
    force_pct = 0;
    request(OPC_FNEG, 32'h4000_0000, 32'h0, 5'd3);
    cycle();
    bus.req_valid = 1'b0;
    repeat (15) cycle();
    chk("to_early", 32'(bus.resp_valid), 32'd0);
    cycle();
    chk("to_valid", 32'(bus.resp_valid), 32'd1);
    chk("to_err", 32'(bus.resp_err), 32'd1);
    chk("to_result", bus.resp_result, 32'd0);
    bus.resp_ready = 1'b1;
    cycle();
    bus.resp_ready = 1'b0;
    force_pct = 100;

    // Invalid opcode: immediate error, no unit selected
    request(2'd3, 32'hDEAD_BEEF, 32'h0, 5'd30);
    cycle();
    bus.req_valid = 1'b0;
    chk("inv_valid", 32'(bus.resp_valid), 32'd1);
    chk("inv_err", 32'(bus.resp_err), 32'd1);
    chk("inv_sel", 32'(bus.unit_sel), 32'd0);
    chk("inv_tag", 32'(bus.resp_tag), 32'd30);
    bus.resp_ready = 1'b1;
    cycle();
    bus.resp_ready = 1'b0;

    // Reset during WAIT drops the op; the next request completes normally
    request(OPC_FADD, 32'h5, 32'h6, 5'd7);
    cycle();
    bus.req_valid = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    chk("mr_req_ready", 32'(bus.req_ready), 32'd1);
    chk("mr_sel", 32'(bus.unit_sel), 32'd0);
    chk("mr_valid", 32'(bus.resp_valid), 32'd0);
    chk("mr_busy", 32'(bus.busy), 32'd0);
    reset = 1'b1;
    bus.resp_ready = 1'b1;
    request(OPC_FNEG, 32'h3F80_0000, 32'h0, 5'd4);
    cycle();
    bus.req_valid = 1'b0;
    cycle();
    cycle();
    chk("mr_after_valid", 32'(bus.resp_valid), 32'd1);
    chk("mr_after_result", bus.resp_result, 32'hBF80_0000);
    chk("mr_after_tag", 32'(bus.resp_tag), 32'd4);
    cycle();

    // Randomized traffic against the model
    force_pct = -1;
    for (int c = 0; c < 4000; c++) begin
      int r = $urandom_range(0, 9);
      bus.req_valid  = ($urandom_range(0, 99) < 50);
      bus.req_opc    = (r < 9) ? 2'(r % 3) : 2'd3;
      bus.req_a      = $urandom;
      bus.req_b      = $urandom;
      bus.req_tag    = 5'($urandom_range(0, 31));
      bus.resp_ready = ($urandom_range(0, 99) < 40);
      reset          = ($urandom_range(0, 299) != 0);
      cycle();
    end
    reset = 1'b1;
    bus.req_valid = 1'b0;
    cycle();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Single-issue sequencer sitting between the core's FP request port and a bank of fixed-latency FPU units (fabs, fneg, fadd-class).
- Accepts one request, broadcasts its operands and selects the target unit, then waits out that unit's latency and its ready flag.
- Captures the result and holds it on a valid/ready response port until the core consumes it.
- A watchdog turns a hung unit into an error response.

Parameters:
N_UNITS, 3, number of attached units; opcode value = unit index
OPC_W, 2, request opcode width
TAG_W, 5, destination tag width (carried through unchanged)
LAT_W, 4, width of each latency field
LATENCIES, 12'h411, packed {LAT[2],LAT[1],LAT[0]}; LAT[i] = unit i register latency, 1..TIMEOUT-1
TIMEOUT, 15, wait-cycle limit before an error completion

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low
req_valid  in  1  request present
req_ready  out  1  controller can accept
req_opc  in  OPC_W  target unit index
req_a  in  32  operand A
req_b  in  32  operand B
req_tag  in  TAG_W  destination tag
unit_a  out  32  registered operand A broadcast to all units
unit_b  out  32  registered operand B broadcast
unit_sel  out  N_UNITS  one-hot select of active unit
unit_result  in  32*N_UNITS  unit i result at bits [32i+31:32i]
unit_ready  in  N_UNITS  unit i ready level
resp_valid  out  1  response present
resp_ready  in  1  core accepts response
resp_result  out  32  captured result
resp_tag  out  TAG_W  tag of completed request
resp_err  out  1  1 = timeout or invalid opcode
busy  out  1  state != IDLE

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, cnt=0.
  - All outputs 0 except req_ready=1.
  - Any in-flight op is dropped; no response is emitted for it.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1, unit_sel=0.
  - On req_valid: latch opc, tag, and operands into unit_a/unit_b; cnt<=0.
    - If opc < N_UNITS: go to WAIT.
    - If opc >= N_UNITS: resp_result<=0, resp_err<=1, go directly to RESP; no unit is ever selected.
- WAIT:
  - req_ready=0, unit_sel=onehot(opc); unit_a/unit_b are held stable.
  - Each edge:
    - If cnt>=LAT[opc] and unit_ready[opc]: resp_result<=unit_result slice, resp_err<=0, go to RESP.
    - Else if cnt==TIMEOUT: resp_result<=0, resp_err<=1, go to RESP.
    - Else: cnt<=cnt+1.
  - Nominal latency: request accepted at edge k gives resp_valid high after edge k+LAT+1. For a 1-cycle unit that is 2 cycles.
  - The unit sees the operands after edge k and registers its result at edge k+LAT. The controller samples it at edge k+LAT+1.
  - Completion and timeout on the same edge: completion wins.
- RESP:
  - resp_valid=1; resp_result, resp_tag and resp_err are stable; unit_sel=0; req_ready=0.
  - On resp_ready: resp_valid<=0, go to IDLE.
  - No same-cycle accept of a new request; the minimum request spacing is LAT+3 cycles.
- Width rules:
  - cnt is LAT_W bits wide; TIMEOUT must be <= 2^LAT_W-1, so cnt never wraps.
  - unit_result slice selected by opc.
- unit_ready of unselected units is ignored.

Decomposition:
- Package fpu_ctrl_pkg: state enum {IDLE, WAIT, RESP}; opcode constants OPC_FABS=0, OPC_FNEG=1, OPC_FADD=2; default latency table.
- No sub-module: the result-slice mux and latency lookup are inline.

Test Plan:
- Unit0 is a 1-cycle abs model. Request opc=0, a=32'hBF800000, resp_ready=1 → resp_valid 2 cycles after accept, result 32'h3F800000, tag echoed, err=0.
- Unit2 has LAT=4. Request opc=2 → unit_sel=3'b100 for exactly 5 cycles, resp_valid on the 5th edge after accept, result equals the unit2 slice.
- Back-pressure: hold resp_ready=0 for 6 cycles → resp_valid, result and tag stable, req_ready=0 throughout; on the resp_ready pulse → IDLE next cycle.
- Timeout: unit_ready[1] stuck 0, request opc=1 → resp_err=1, result=0 after TIMEOUT+1 WAIT edges.
- Invalid opcode: request opc=3 → resp_valid on the next edge, err=1, unit_sel never nonzero.
- Mid-operation reset: reset=0 during WAIT of an opc=2 request → next cycle IDLE, unit_sel=0, resp_valid=0, req_ready=1; a following request completes normally.
